// File: rtl/cam_bram_pipe.sv
// rtl/cam_bram_pipe.sv - sliced block-RAM CAM with pipelined search and write/delete FSM
// Optional output register stage enabled by defining CAM_OUT_REG_EN.
module cam_bram_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_delete,
    input  logic                  srch_valid,
    input  logic [DATA_WIDTH-1:0] srch_data,
    output logic                  res_valid,
    output logic                  res_match,
    output logic                  res_multi,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  init_done
);
    localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
    localparam int DEPTH       = 1 << ADDR_WIDTH;
    localparam int RAM_DEPTH   = 1 << SLICE_WIDTH;
    localparam int PAD_W       = SLICE_COUNT * SLICE_WIDTH;

    typedef enum logic [2:0] {INIT, IDLE, RD_OLD, CLR, SET_RD, SET} state_t;

    // Zero-extend so the last slice's unused upper bits address as 0.
    function automatic logic [SLICE_WIDTH-1:0] key_slice(input logic [DATA_WIDTH-1:0] key,
                                                         input int idx);
        logic [PAD_W-1:0] pad;
        pad = PAD_W'(key);
        return pad[idx*SLICE_WIDTH +: SLICE_WIDTH];
    endfunction

    state_t state, state_next;
    logic [SLICE_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_data, old_key;
    logic                   lat_delete, was_valid;
    logic [DEPTH-1:0]       valid_map, entry_bit;
    logic [ADDR_WIDTH:0]    count;
    logic [DATA_WIDTH-1:0]  shadow [DEPTH];

    logic                                    ram_we;
    logic [SLICE_COUNT-1:0][SLICE_WIDTH-1:0] ram_waddr, fsm_raddr, srch_raddr;
    logic [SLICE_COUNT-1:0][DEPTH-1:0]       ram_wdata, fsm_vec, srch_vec;

    assign entry_bit   = DEPTH'(1) << lat_addr;
    assign wr_ready    = (state == IDLE);
    assign entry_count = count;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        fsm_raddr  = '0;
        case (state)
            INIT: begin
                ram_we = 1'b1;
                for (int s = 0; s < SLICE_COUNT; s++) ram_waddr[s] = init_cnt;
                if (init_cnt == '0) state_next = IDLE;
            end
            IDLE: if (wr_valid) state_next = RD_OLD;
            RD_OLD: begin
                for (int s = 0; s < SLICE_COUNT; s++) fsm_raddr[s] = key_slice(shadow[lat_addr], s);
                state_next = CLR;
            end
            CLR: begin
                // An invalid entry's shadow key is stale, so its slices must not be touched.
                ram_we = valid_map[lat_addr];
                for (int s = 0; s < SLICE_COUNT; s++) begin
                    ram_waddr[s] = key_slice(old_key, s);
                    ram_wdata[s] = fsm_vec[s] & ~entry_bit;
                end
                state_next = lat_delete ? IDLE : SET_RD;
            end
            SET_RD: begin
                for (int s = 0; s < SLICE_COUNT; s++) fsm_raddr[s] = key_slice(lat_data, s);
                state_next = SET;
            end
            SET: begin
                ram_we = 1'b1;
                for (int s = 0; s < SLICE_COUNT; s++) begin
                    ram_waddr[s] = key_slice(lat_data, s);
                    ram_wdata[s] = fsm_vec[s] | entry_bit;
                end
                state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt   <= '1;
            init_done  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_delete <= 1'b0;
            old_key    <= '0;
            was_valid  <= 1'b0;
            valid_map  <= '0;
            count      <= '0;
        end else begin
            if (state == INIT) begin
                init_cnt <= init_cnt - 1'b1;
                if (init_cnt == '0) init_done <= 1'b1;
            end
            if (state == IDLE && wr_valid) begin
                lat_addr   <= wr_addr;
                lat_data   <= wr_data;
                lat_delete <= wr_delete;
            end
            if (state == RD_OLD) old_key <= shadow[lat_addr];
            if (state == CLR) begin
                was_valid <= valid_map[lat_addr];
                if (valid_map[lat_addr]) begin
                    valid_map[lat_addr] <= 1'b0;
                    if (lat_delete) count <= count - 1'b1;
                end
            end
            if (state == SET) begin
                valid_map[lat_addr] <= 1'b1;
                if (!was_valid) count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == SET) shadow[lat_addr] <= lat_data;
    end

    always_comb begin
        for (int s = 0; s < SLICE_COUNT; s++) srch_raddr[s] = key_slice(srch_data, s);
    end

    for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
        logic [DEPTH-1:0] ram [RAM_DEPTH];
        logic [DEPTH-1:0] fsm_q, srch_q;
        // Read-before-write: a search sampled in the SET cycle still sees old contents.
        always_ff @(posedge clk) begin
            if (ram_we) ram[ram_waddr[s]] <= ram_wdata[s];
            fsm_q  <= ram[fsm_raddr[s]];
            srch_q <= ram[srch_raddr[s]];
        end
        assign fsm_vec[s]  = fsm_q;
        assign srch_vec[s] = srch_q;
    end

    logic                  s1_valid, hit_multi;
    logic [DEPTH-1:0]      hit_vec;
    logic [ADDR_WIDTH-1:0] enc_addr;

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= srch_valid;
    end

    always_comb begin
        hit_vec = valid_map;
        for (int s = 0; s < SLICE_COUNT; s++) hit_vec = hit_vec & srch_vec[s];
        enc_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) if (hit_vec[i]) enc_addr = ADDR_WIDTH'(i);
        hit_multi = |(hit_vec & (hit_vec - DEPTH'(1)));
    end

    logic                  r_valid, r_match, r_multi;
    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_multi <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_valid <= s1_valid;
            r_match <= s1_valid & (|hit_vec);
            r_multi <= s1_valid & hit_multi;
            r_addr  <= s1_valid ? enc_addr : '0;
        end
    end

`ifdef CAM_OUT_REG_EN
    logic                  o_valid, o_match, o_multi;
    logic [ADDR_WIDTH-1:0] o_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_match <= 1'b0;
            o_multi <= 1'b0;
            o_addr  <= '0;
        end else begin
            o_valid <= r_valid;
            o_match <= r_match;
            o_multi <= r_multi;
            o_addr  <= r_addr;
        end
    end

    assign res_valid = o_valid;
    assign res_match = o_match;
    assign res_multi = o_multi;
    assign res_addr  = o_addr;
`else
    assign res_valid = r_valid;
    assign res_match = r_match;
    assign res_multi = r_multi;
    assign res_addr  = r_addr;
`endif
endmodule

// File: tb/tb_cam_bram_pipe.sv
// tb/tb_cam_bram_pipe.sv - directed table-driven bench for cam_bram_pipe
module tb_cam_bram_pipe;
`ifdef CAM_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready, wr_delete;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        srch_valid;
    logic [31:0] srch_data;
    logic        res_valid, res_match, res_multi;
    logic [4:0]  res_addr;
    logic [5:0]  entry_count;
    logic        init_done;

    int errors = 0;
    int checks = 0;

    cam_bram_pipe dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_delete(wr_delete),
        .srch_valid(srch_valid), .srch_data(srch_data),
        .res_valid(res_valid), .res_match(res_match), .res_multi(res_multi),
        .res_addr(res_addr), .entry_count(entry_count), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (wr_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    endtask

    task automatic do_wr(input logic del, input logic [4:0] a, input logic [31:0] d);
        wait_ready();
        wr_valid  = 1'b1;
        wr_delete = del;
        wr_addr   = a;
        wr_data   = d;
        step();
        wr_valid = 1'b0;
        check("wr_ready_drop", {31'd0, wr_ready}, 32'd0);
    endtask

    task automatic do_srch(input logic [31:0] d, input logic m, input logic mu,
                           input logic [4:0] a, input logic [5:0] cnt);
        wait_ready();
        srch_valid = 1'b1;
        srch_data  = d;
        step();
        srch_valid = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            check("res_valid_early", {31'd0, res_valid}, 32'd0);
            step();
        end
        check("res_valid", {31'd0, res_valid}, 32'd1);
        check("res_match", {31'd0, res_match}, {31'd0, m});
        check("res_multi", {31'd0, res_multi}, {31'd0, mu});
        check("res_addr", {27'd0, res_addr}, {27'd0, a});
        check("entry_count", {26'd0, entry_count}, {26'd0, cnt});
    endtask

    // Counts cycles from reset release until init_done; drives one search during INIT.
    task automatic run_init(input bit with_search);
        int rise = -1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (init_done === 1'b1 && rise < 0) rise = k;
            if (with_search && k == 10) begin
                srch_valid = 1'b1;
                srch_data  = 32'h0;
            end
            if (with_search && k == 11) srch_valid = 1'b0;
            if (with_search && k == 10 + LAT) begin
                check("init_srch_valid", {31'd0, res_valid}, 32'd1);
                check("init_srch_match", {31'd0, res_match}, 32'd0);
            end
        end
        check("init_done_cycle", rise, 32'd256);
    endtask

    typedef struct {
        logic [1:0]  op;   // 0 write, 1 delete, 2 search
        logic [4:0]  addr;
        logic [31:0] data;
        logic        m;
        logic        mu;
        logic [4:0]  a;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs [14];
    logic [31:0] ow_key [8];
    logic        ow_exp [8];

    initial begin
        vecs[0]  = '{2'd0, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 6'd0};
        vecs[1]  = '{2'd2, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 5'd3, 6'd1};
        vecs[2]  = '{2'd0, 5'd7, 32'h12345678, 1'b0, 1'b0, 5'd0, 6'd0};
        vecs[3]  = '{2'd0, 5'd2, 32'h12345678, 1'b0, 1'b0, 5'd0, 6'd0};
        vecs[4]  = '{2'd2, 5'd0, 32'h12345678, 1'b1, 1'b1, 5'd2, 6'd3};
        vecs[5]  = '{2'd2, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 5'd3, 6'd3};
        vecs[6]  = '{2'd0, 5'd3, 32'h00000000, 1'b0, 1'b0, 5'd0, 6'd0};
        vecs[7]  = '{2'd1, 5'd9, 32'h00000000, 1'b0, 1'b0, 5'd0, 6'd0};
        vecs[8]  = '{2'd2, 5'd0, 32'h00000000, 1'b1, 1'b0, 5'd3, 6'd3};
        vecs[9]  = '{2'd2, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 6'd3};
        vecs[10] = '{2'd1, 5'd7, 32'h00000000, 1'b0, 1'b0, 5'd0, 6'd0};
        vecs[11] = '{2'd2, 5'd0, 32'h12345678, 1'b1, 1'b0, 5'd2, 6'd2};
        vecs[12] = '{2'd0, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 6'd0};
        vecs[13] = '{2'd2, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 5'd3, 6'd2};

        // Search keys per cycle of an overwrite: C0 IDLE, C1 RD_OLD, C2 CLR, C3 SET_RD, C4 SET.
        ow_key = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hCAFEF00D,
                   32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF};
        ow_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; wr_valid = 1'b0; wr_delete = 1'b0; wr_addr = '0; wr_data = '0;
        srch_valid = 1'b0; srch_data = '0;
        repeat (3) step();
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_match", {31'd0, res_match}, 32'd0);
        check("rst_res_addr", {27'd0, res_addr}, 32'd0);
        check("rst_entry_count", {26'd0, entry_count}, 32'd0);
        rst = 1'b0;
        run_init(1'b1);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].op == 2'd2)
                do_srch(vecs[i].data, vecs[i].m, vecs[i].mu, vecs[i].a, vecs[i].cnt);
            else
                do_wr(vecs[i].op == 2'd1, vecs[i].addr, vecs[i].data);
        end

        wait_ready();
        wr_valid = 1'b1; wr_delete = 1'b0; wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
        srch_valid = 1'b1; srch_data = ow_key[0];
        for (int j = 0; j < 8 + LAT - 1; j++) begin
            step();
            wr_valid = 1'b0;
            if (j + 1 < 8) srch_data = ow_key[j + 1];
            else           srch_valid = 1'b0;
            if (j + 1 >= LAT) begin
                check("ow_valid", {31'd0, res_valid}, 32'd1);
                check("ow_match", {31'd0, res_match}, {31'd0, ow_exp[j + 1 - LAT]});
                check("ow_addr", {27'd0, res_addr}, ow_exp[j + 1 - LAT] ? 32'd3 : 32'd0);
                check("ow_count", {26'd0, entry_count}, 32'd2);
            end
        end

        wait_ready();
        wr_valid = 1'b1; wr_delete = 1'b0; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
        step();
        wr_valid = 1'b0;
        step();
        srch_valid = 1'b1; srch_data = 32'hCAFEF00D;
        step();
        srch_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("mid_rst_count", {26'd0, entry_count}, 32'd0);
        step();
        rst = 1'b0;
        check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
        run_init(1'b0);
        do_srch(32'hA5A5A5A5, 1'b0, 1'b0, 5'd0, 6'd0);
        do_srch(32'hCAFEF00D, 1'b0, 1'b0, 5'd0, 6'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
